// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, captures CDB results and
// retires strictly in order, flushing everything on a mispredicted branch.
module reorder_buffer #(
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 rdy_in,
   input  logic                 issue_signal,
   input  logic [4:0]           issue_rd_id,
   input  logic                 issue_is_branch,
   input  logic                 issue_pred_taken,
   input  logic [31:0]          issue_alt_pc,
   output logic [ROB_WIDTH-1:0] issue_tag,
   output logic                 rob_full,
   input  logic                 wb_signal,
   input  logic [ROB_WIDTH-1:0] wb_tag,
   input  logic [31:0]          wb_value,
   input  logic                 wb_taken,
   input  logic [ROB_WIDTH-1:0] query_tag_1,
   input  logic [ROB_WIDTH-1:0] query_tag_2,
   output logic                 query_ready_1,
   output logic                 query_ready_2,
   output logic [31:0]          query_value_1,
   output logic [31:0]          query_value_2,
   output logic                 rob_commit_signal,
   output logic [4:0]           commit_rd_id,
   output logic [ROB_WIDTH-1:0] commit_rd_tag,
   output logic [31:0]          commit_rd_value,
   output logic                 clear_signal,
   output logic [31:0]          clear_pc
);
   localparam int DEPTH = 1 << ROB_WIDTH;
   localparam logic [ROB_WIDTH-1:0] PTR_ONE  = {{(ROB_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ROB_WIDTH:0]   CNT_ONE  = {{ROB_WIDTH{1'b0}}, 1'b1};
   localparam logic [ROB_WIDTH:0]   CNT_FULL = {1'b1, {ROB_WIDTH{1'b0}}};

   logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
   logic [ROB_WIDTH:0]   count_q, count_d;
   logic [DEPTH-1:0]     busy_q, busy_d, ready_q, ready_d;
   logic [DEPTH-1:0]     is_br_q, is_br_d, pred_q, pred_d, taken_q, taken_d;
   logic [4:0]           rd_id_q  [DEPTH];
   logic [4:0]           rd_id_d  [DEPTH];
   logic [31:0]          value_q  [DEPTH];
   logic [31:0]          value_d  [DEPTH];
   logic [31:0]          alt_pc_q [DEPTH];
   logic [31:0]          alt_pc_d [DEPTH];
   logic                 commit_q, commit_d, clear_q, clear_d;
   logic [4:0]           c_rd_id_q, c_rd_id_d;
   logic [ROB_WIDTH-1:0] c_tag_q, c_tag_d;
   logic [31:0]          c_value_q, c_value_d, clear_pc_q, clear_pc_d;
   logic                 issue_acc_s, wb_acc_s, head_ok_s, mispredict_s, retire_s;

   assign issue_tag         = tail_q;
   assign rob_full          = (count_q == CNT_FULL);
   assign rob_commit_signal = commit_q;
   assign commit_rd_id      = c_rd_id_q;
   assign commit_rd_tag     = c_tag_q;
   assign commit_rd_value   = c_value_q;
   assign clear_signal      = clear_q;
   assign clear_pc          = clear_pc_q;

   // Operand lookup with same-cycle forwarding from the writeback bus
   always_comb begin
      query_ready_1 = ready_q[query_tag_1] | (wb_signal & (wb_tag == query_tag_1));
      query_ready_2 = ready_q[query_tag_2] | (wb_signal & (wb_tag == query_tag_2));
      query_value_1 = (wb_signal & (wb_tag == query_tag_1)) ? wb_value : value_q[query_tag_1];
      query_value_2 = (wb_signal & (wb_tag == query_tag_2)) ? wb_value : value_q[query_tag_2];
   end

   // Next-state: writeback, issue, in-order retire and mispredict flush
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      busy_d     = busy_q;
      ready_d    = ready_q;
      is_br_d    = is_br_q;
      pred_d     = pred_q;
      taken_d    = taken_q;
      rd_id_d    = rd_id_q;
      value_d    = value_q;
      alt_pc_d   = alt_pc_q;
      c_rd_id_d  = c_rd_id_q;
      c_tag_d    = c_tag_q;
      c_value_d  = c_value_q;
      clear_pc_d = clear_pc_q;

      issue_acc_s  = rdy_in & issue_signal & ~rob_full & ~clear_q;
      wb_acc_s     = rdy_in & wb_signal & busy_q[wb_tag] & ~clear_q;
      head_ok_s    = rdy_in & ~clear_q & busy_q[head_q] & ready_q[head_q];
      mispredict_s = is_br_q[head_q] & (taken_q[head_q] != pred_q[head_q]);
      retire_s     = head_ok_s & ~mispredict_s;

      // Pulses drop on every enabled edge; a stalled edge keeps them
      if (rdy_in) begin
         commit_d = 1'b0;
         clear_d  = 1'b0;
      end else begin
         commit_d = commit_q;
         clear_d  = clear_q;
      end

      if (wb_acc_s) begin
         ready_d[wb_tag] = 1'b1;
         value_d[wb_tag] = wb_value;
         taken_d[wb_tag] = wb_taken;
      end else begin
         ready_d = ready_d;
      end

      if (issue_acc_s) begin
         busy_d[tail_q]   = 1'b1;
         ready_d[tail_q]  = 1'b0;
         rd_id_d[tail_q]  = issue_rd_id;
         is_br_d[tail_q]  = issue_is_branch;
         pred_d[tail_q]   = issue_pred_taken;
         alt_pc_d[tail_q] = issue_alt_pc;
         tail_d           = tail_q + PTR_ONE;
      end else begin
         tail_d = tail_q;
      end

      if (retire_s) begin
         commit_d       = 1'b1;
         c_rd_id_d      = rd_id_q[head_q];
         c_tag_d        = head_q;
         c_value_d      = value_q[head_q];
         busy_d[head_q] = 1'b0;
         head_d         = head_q + PTR_ONE;
      end else begin
         head_d = head_q;
      end

      case ({issue_acc_s, retire_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // A wrong-path branch at the head discards every younger entry
      if (head_ok_s & mispredict_s) begin
         clear_d    = 1'b1;
         clear_pc_d = alt_pc_q[head_q];
         busy_d     = '0;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else begin
         clear_pc_d = clear_pc_d;
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         busy_q     <= '0;
         ready_q    <= '0;
         is_br_q    <= '0;
         pred_q     <= '0;
         taken_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_id_q[i]  <= 5'd0;
            value_q[i]  <= 32'd0;
            alt_pc_q[i] <= 32'd0;
         end
         commit_q   <= 1'b0;
         c_rd_id_q  <= 5'd0;
         c_tag_q    <= '0;
         c_value_q  <= 32'd0;
         clear_q    <= 1'b0;
         clear_pc_q <= 32'd0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         is_br_q    <= is_br_d;
         pred_q     <= pred_d;
         taken_q    <= taken_d;
         rd_id_q    <= rd_id_d;
         value_q    <= value_d;
         alt_pc_q   <= alt_pc_d;
         commit_q   <= commit_d;
         c_rd_id_q  <= c_rd_id_d;
         c_tag_q    <= c_tag_d;
         c_value_q  <= c_value_d;
         clear_q    <= clear_d;
         clear_pc_q <= clear_pc_d;
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic
// compared against a tag-indexed program-order model.
module tb_reorder_buffer;
   localparam int W     = 4;
   localparam int DEPTH = 16;

   logic         clk_in = 1'b0, rst_n_in = 1'b0, rdy_in;
   logic         issue_signal, issue_is_branch, issue_pred_taken;
   logic [4:0]   issue_rd_id;
   logic [31:0]  issue_alt_pc;
   logic [W-1:0] issue_tag;
   logic         rob_full;
   logic         wb_signal, wb_taken;
   logic [W-1:0] wb_tag, query_tag_1, query_tag_2;
   logic [31:0]  wb_value;
   logic         query_ready_1, query_ready_2;
   logic [31:0]  query_value_1, query_value_2;
   logic         rob_commit_signal, clear_signal;
   logic [4:0]   commit_rd_id;
   logic [W-1:0] commit_rd_tag;
   logic [31:0]  commit_rd_value, clear_pc;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: per-tag contents, head index and occupancy
   bit          m_busy [DEPTH];
   bit          m_ready[DEPTH];
   bit          m_br   [DEPTH];
   bit          m_pred [DEPTH];
   bit          m_tkn  [DEPTH];
   logic [4:0]  m_rd   [DEPTH];
   logic [31:0] m_val  [DEPTH];
   logic [31:0] m_alt  [DEPTH];
   int          m_head, m_count;
   bit          e_commit, e_clear;
   logic [4:0]  e_id;
   logic [31:0] e_tag, e_val, e_pc;

   reorder_buffer #(.ROB_WIDTH(W)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .issue_signal(issue_signal), .issue_rd_id(issue_rd_id),
      .issue_is_branch(issue_is_branch), .issue_pred_taken(issue_pred_taken),
      .issue_alt_pc(issue_alt_pc), .issue_tag(issue_tag), .rob_full(rob_full),
      .wb_signal(wb_signal), .wb_tag(wb_tag), .wb_value(wb_value), .wb_taken(wb_taken),
      .query_tag_1(query_tag_1), .query_tag_2(query_tag_2),
      .query_ready_1(query_ready_1), .query_ready_2(query_ready_2),
      .query_value_1(query_value_1), .query_value_2(query_value_2),
      .rob_commit_signal(rob_commit_signal), .commit_rd_id(commit_rd_id),
      .commit_rd_tag(commit_rd_tag), .commit_rd_value(commit_rd_value),
      .clear_signal(clear_signal), .clear_pc(clear_pc)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_busy[i] = 0; m_ready[i] = 0; m_br[i] = 0; m_pred[i] = 0; m_tkn[i] = 0;
         m_rd[i] = 5'd0; m_val[i] = 32'd0; m_alt[i] = 32'd0;
      end
      m_head = 0; m_count = 0;
      e_commit = 0; e_clear = 0; e_id = 5'd0; e_tag = 32'd0; e_val = 32'd0; e_pc = 32'd0;
   endtask

   // Apply the buffer's rules for one clock edge to the model
   task automatic model_edge();
      int  tail;
      bit  iss, wba, com, mis;
      if (!rdy_in) return;
      tail = (m_head + m_count) % DEPTH;
      iss  = issue_signal && (m_count < DEPTH) && !e_clear;
      wba  = wb_signal && m_busy[wb_tag] && !e_clear;
      com  = !e_clear && m_busy[m_head] && m_ready[m_head];
      mis  = com && m_br[m_head] && (m_tkn[m_head] != m_pred[m_head]);
      e_commit = 0;
      e_clear  = 0;
      if (mis) begin
         e_clear = 1;
         e_pc    = m_alt[m_head];
         for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
         m_head  = 0;
         m_count = 0;
      end else begin
         if (com) begin
            e_commit = 1; e_id = m_rd[m_head]; e_tag = m_head; e_val = m_val[m_head];
            m_busy[m_head] = 0;
            m_head  = (m_head + 1) % DEPTH;
            m_count = m_count - 1;
         end
         if (wba) begin
            m_ready[wb_tag] = 1; m_val[wb_tag] = wb_value; m_tkn[wb_tag] = wb_taken;
         end
         if (iss) begin
            m_busy[tail] = 1; m_ready[tail] = 0; m_rd[tail] = issue_rd_id;
            m_br[tail] = issue_is_branch; m_pred[tail] = issue_pred_taken; m_alt[tail] = issue_alt_pc;
            m_count = m_count + 1;
         end
      end
   endtask

   task automatic check_query(input string tag, input logic [W-1:0] q,
                              input logic rdy_o, input logic [31:0] val_o);
      if (wb_signal && wb_tag == q) begin
         check({tag, "_fwd_rdy"}, rdy_o, 1);
         check({tag, "_fwd_val"}, val_o, wb_value);
      end else if (m_busy[q]) begin
         check({tag, "_rdy"}, rdy_o, m_ready[q]);
         if (m_ready[q]) check({tag, "_val"}, val_o, m_val[q]);
      end
   endtask

   // One full cycle: combinational checks, edge, registered checks
   task automatic step();
      #1;
      check("issue_tag", issue_tag, (m_head + m_count) % DEPTH);
      check("rob_full", rob_full, (m_count == DEPTH));
      check_query("q1", query_tag_1, query_ready_1, query_value_1);
      check_query("q2", query_tag_2, query_ready_2, query_value_2);
      @(posedge clk_in);
      model_edge();
      @(negedge clk_in);
      check("commit", rob_commit_signal, e_commit);
      check("clear", clear_signal, e_clear);
      if (e_commit) begin
         check("commit_id", commit_rd_id, e_id);
         check("commit_tag", commit_rd_tag, e_tag);
         check("commit_val", commit_rd_value, e_val);
      end
      if (e_clear) check("clear_pc", clear_pc, e_pc);
   endtask

   task automatic idle();
      rdy_in = 1'b1; issue_signal = 1'b0; issue_rd_id = 5'd0; issue_is_branch = 1'b0;
      issue_pred_taken = 1'b0; issue_alt_pc = 32'd0; wb_signal = 1'b0; wb_tag = '0;
      wb_value = 32'd0; wb_taken = 1'b0; query_tag_1 = '0; query_tag_2 = '0;
   endtask

   task automatic do_issue(input logic [4:0] rd, input logic br, input logic pred, input logic [31:0] alt);
      idle();
      issue_signal = 1'b1; issue_rd_id = rd; issue_is_branch = br;
      issue_pred_taken = pred; issue_alt_pc = alt;
      step();
   endtask

   task automatic do_wb(input int tag, input logic [31:0] val, input logic tkn);
      idle();
      wb_signal = 1'b1; wb_tag = W'(tag); wb_value = val; wb_taken = tkn;
      step();
   endtask

   task automatic do_reset();
      idle();
      rst_n_in = 1'b0;
      #1;
      model_reset();
      check("rst_commit", rob_commit_signal, 0);
      check("rst_clear", clear_signal, 0);
      check("rst_tag", issue_tag, 0);
      check("rst_full", rob_full, 0);
      @(posedge clk_in);
      @(negedge clk_in);
      rst_n_in = 1'b1;
   endtask

   initial begin
      bit seen;
      idle();
      do_reset();

      // Basic commit
      do_issue(5'd5, 1'b0, 1'b0, 32'd0);
      do_wb(0, 32'h1234, 1'b0);
      idle(); step();
      check("basic_commit", rob_commit_signal, 1);
      check("basic_id", commit_rd_id, 5);
      check("basic_tag", commit_rd_tag, 0);
      check("basic_val", commit_rd_value, 32'h1234);

      // In-order retirement with reverse-order writeback
      do_reset();
      for (int i = 0; i < 3; i++) do_issue(5'(i + 1), 1'b0, 1'b0, 32'd0);
      do_wb(2, 32'hA2, 1'b0);
      check("io_none_a", rob_commit_signal, 0);
      do_wb(1, 32'hA1, 1'b0);
      check("io_none_b", rob_commit_signal, 0);
      do_wb(0, 32'hA0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle(); step();
         check("io_order", commit_rd_tag, i);
      end

      // Full and wrap
      do_reset();
      for (int i = 0; i < DEPTH; i++) do_issue(5'(i + 1), 1'b0, 1'b0, 32'd0);
      check("full_set", rob_full, 1);
      do_issue(5'd31, 1'b0, 1'b0, 32'd0);
      check("full_reject", rob_full, 1);
      do_wb(0, 32'h77, 1'b0);
      idle(); step();
      check("full_drop", rob_full, 0);
      idle(); issue_signal = 1'b1; issue_rd_id = 5'd9;
      #1 check("wrap_tag", issue_tag, 0);
      step();

      // Mispredict flush
      do_reset();
      for (int i = 0; i < 3; i++) do_issue(5'(i + 1), 1'b0, 1'b0, 32'd0);
      do_issue(5'd0, 1'b1, 1'b0, 32'h100);
      do_issue(5'd6, 1'b0, 1'b0, 32'd0);
      do_issue(5'd7, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) do_wb(i, 32'(i + 16), (i == 3));
      seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin
         idle(); step();
         seen = e_clear;
      end
      check("mp_seen", seen, 1);
      check("mp_clear", clear_signal, 1);
      check("mp_pc", clear_pc, 32'h100);
      check("mp_nocommit", rob_commit_signal, 0);
      do_issue(5'd8, 1'b0, 1'b0, 32'd0);
      do_issue(5'd9, 1'b0, 1'b0, 32'd0);
      idle(); #1 check("mp_count1", issue_tag, 1);
      step();

      // Query forwarding
      do_reset();
      for (int i = 0; i < 3; i++) do_issue(5'(i + 1), 1'b0, 1'b0, 32'd0);
      idle(); wb_signal = 1'b1; wb_tag = 4'd2; wb_value = 32'hBEEF;
      query_tag_1 = 4'd2; query_tag_2 = 4'd1;
      #1;
      check("qf_rdy", query_ready_1, 1);
      check("qf_val", query_value_1, 32'hBEEF);
      check("qf_notrdy", query_ready_2, 0);
      step();

      // Stall with a ready head, then hold of a raised pulse
      do_reset();
      do_issue(5'd4, 1'b0, 1'b0, 32'd0);
      do_wb(0, 32'h55, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle(); rdy_in = 1'b0; step();
         check("stall_nocommit", rob_commit_signal, 0);
      end
      idle(); step();
      check("stall_release", rob_commit_signal, 1);
      for (int i = 0; i < 2; i++) begin
         idle(); rdy_in = 1'b0; issue_signal = 1'b1; step();
         check("stall_hold", rob_commit_signal, 1);
         check("stall_hold_val", commit_rd_value, 32'h55);
      end

      // Asynchronous reset with the buffer half full
      do_reset();
      for (int i = 0; i < 8; i++) do_issue(5'(i + 1), 1'b0, 1'b0, 32'd0);
      do_wb(0, 32'hCAFE, 1'b0);
      idle(); step();
      check("ar_pre", rob_commit_signal, 1);
      @(posedge clk_in);
      #2 rst_n_in = 1'b0;
      #1;
      check("ar_commit", rob_commit_signal, 0);
      check("ar_id", commit_rd_id, 0);
      check("ar_tag", commit_rd_tag, 0);
      check("ar_val", commit_rd_value, 0);
      check("ar_clear", clear_signal, 0);
      check("ar_pc", clear_pc, 0);
      check("ar_itag", issue_tag, 0);
      check("ar_full", rob_full, 0);
      model_reset();
      @(negedge clk_in);
      rst_n_in = 1'b1;

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         int pend[$];
         idle();
         rdy_in           = ($urandom_range(0, 9) != 0);
         issue_signal     = ($urandom_range(0, 9) < 6);
         issue_rd_id      = 5'($urandom);
         issue_is_branch  = ($urandom_range(0, 4) == 0);
         issue_pred_taken = 1'($urandom);
         issue_alt_pc     = $urandom;
         for (int t = 0; t < DEPTH; t++) if (m_busy[t] && !m_ready[t]) pend.push_back(t);
         if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
            wb_signal = 1'b1;
            wb_tag    = W'(pend[$urandom_range(0, pend.size() - 1)]);
         end else begin
            wb_signal = ($urandom_range(0, 4) == 0);
            wb_tag    = W'($urandom);
         end
         wb_value    = $urandom;
         wb_taken    = ($urandom_range(0, 3) == 0) ? ~m_pred[wb_tag] : m_pred[wb_tag];
         query_tag_1 = W'($urandom);
         query_tag_2 = W'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
